ycr1_wbb_sram_ctrl: RTL and testbench
=====================================

// Module: ycr1_wbb_sram_ctrl
// PURPOSE
//  Burst Wishbone slave sitting on the slave side of the async Wishbone bridge.
//  Terminates wbs_* bursts (bl/bry/lack protocol) onto a single-port, 1-cycle-read SRAM macro.
//  It generates per-beat ack, last-beat lack and out-of-range err.
//  Used as the tightly coupled instruction/data SRAM backing the cache refill path.
// PARAMETERS
//  AW       32          Wishbone byte-address width
//  DW       32          data width; BW = DW/8
//  BL       10          burst-count width (1 = one DW beat)
//  MEM_AW   9           SRAM word-address width (512 words)
//  BASE_ADR 32'h0800_0000  region base; decode on adr[AW-1:MEM_AW+2]
// PORTS
//  wbs_clk_i    in   1       single clock
//  wbs_rst_n    in   1       async active-low reset
//  wbs_cyc_i    in   1       bus cycle
//  wbs_stb_i    in   1       strobe; held high for the whole burst
//  wbs_adr_i    in   AW      start byte address (sampled in IDLE only)
//  wbs_we_i     in   1       1 = write burst
//  wbs_dat_i    in   DW      write data, valid when wbs_bry_i=1
//  wbs_sel_i    in   BW      byte enables per write beat
//  wbs_bl_i     in   BL      burst length, sampled in IDLE; 0 is treated as 1
//  wbs_bry_i    in   1       write: wdata valid; read: master can take data
//  wbs_dat_o    out  DW      read data (= sram_dout_i)
//  wbs_ack_o    out  1       beat ack
//  wbs_lack_o   out  1       last-beat ack (only ever high with wbs_ack_o)
//  wbs_err_o    out  1       error, only ever high with wbs_ack_o
//  sram_csb_o   out  1       SRAM chip select, active low
//  sram_web_o   out  1       SRAM write enable, active low
//  sram_wmask_o out  BW      SRAM byte mask
//  sram_addr_o  out  MEM_AW  SRAM word address
//  sram_din_o   out  DW      SRAM write data
//  sram_dout_i  in   DW      SRAM read data, valid 1 cycle after read select
// BEHAVIOUR
//  Reset values:
//   - ack/lack/err = 0, csb = 1, web = 1, wmask = 0, addr = 0; state = IDLE.
//   - Reset mid-burst aborts immediately: no further SRAM strobes and no pending ack.
//  FSM: IDLE, WR, RD, GAP.
//   - IDLE: on cyc&stb, latch word addr = adr[MEM_AW+1:2], cnt = max(bl,1), err_f = decode miss, we_f = we.
//     Next state is WR or RD. No ack and no SRAM access occur in the IDLE cycle.
//   - WR: a beat fires when stb & bry.
//     Beat (comb.): csb = 0 and web = 0 unless err_f; wmask = sel; din = dat_i; ack = 1; err = err_f.
//     Beat also does addr++ and cnt--. lack = beat & (cnt==1); then go to GAP.
//   - RD: issue = bry & (cnt!=0) & !err_f drives csb = 0, web = 1; addr++, cnt--.
//     Registered pend <= issue, pend_last <= issue & (cnt==1).
//     ack = pend; lack = pend & pend_last; dat_o = sram_dout_i. Read latency is 1 cycle, full throughput.
//     err_f in RD: beat = bry & (cnt!=0); ack = err = 1 same cycle, dat_o = 0, no SRAM access.
//     After lack, go to GAP.
//   - GAP: one cycle, stb ignored; covers the bridge's 1-cycle stb drop after lack. Next state IDLE.
//  Flow control:
//   - bry low stalls issue. A read already issued (pend) is acked even if bry fell.
//   - The bridge's afull margin absorbs that one beat.
//  Address: word counter wraps modulo 2^MEM_AW inside the burst, with no err at the wrap.
//  stb dropping mid-burst (master protocol error): the FSM holds state and resumes when stb returns. Not recovered otherwise.
//  Simultaneous last write beat and a new request: the new request is only sampled after GAP→IDLE.
// STRUCTURE
//  - Package ycr1_wbb_pkg: state enum (IDLE/WR/RD/GAP) and a region-decode helper function.
//  - Single flat module: FSM, addr/cnt counters and read pend pipeline (~200 lines).
//  - No sub-module. The SRAM macro is instantiated by the parent.
// TESTING
//  1. Single write: bl=1, adr=BASE+0x10, sel=4'hF, dat=0xA5A5_0001, bry=1 -> one ack+lack, sram addr 4, web=0, then GAP, IDLE.
//  2. Burst read of 8 with bry=1 (SRAM preloaded addr n = n) -> 8 consecutive acks starting 2 cycles after stb.
//     Data 0..7; lack only on the 8th beat.
//  3. Burst write of 4 with bry toggling 1,0,1,1,0,1 -> exactly 4 SRAM writes at addrs 0..3.
//     Acks only in bry cycles; lack on the 4th.
//  4. Out-of-range read, adr=BASE+0x1000, bl=3 -> 3 acks all with err=1; csb stays 1 throughout.
//  5. Wrap: bl=4 starting at word 510 -> SRAM addrs 510, 511, 0, 1; no err.
//  6. Assert wbs_rst_n low after the 3rd of 8 read beats -> ack/csb return to idle values asynchronously.
//     A fresh bl=1 read after release completes normally. bl=0 behaves exactly as bl=1.

Source files
------------

// File: rtl/ycr1_wbb_sram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ycr1_wbb_pkg
// Shared types and helpers for the burst Wishbone SRAM controller.
//   wbb_state_e : controller FSM states (idle, write burst, read burst, gap)
//   region_hit  : region decode on the address bits above the SRAM window
// ----------------------------------------------------------------------------
package ycr1_wbb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2,
        StGap  = 2'd3
    } wbb_state_e;

    // True when adr and base agree on every bit at or above position lsb.
    function automatic logic region_hit(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input int unsigned lsb);
        return (adr >> lsb) == (base >> lsb);
    endfunction

endpackage

// File: rtl/ycr1_wbb_sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// ycr1_wbb_sram_ctrl_if
// Burst Wishbone bus (bl/bry/lack flavour) between the bridge master side
// and the SRAM controller slave side. Signal names follow the slave view.
//   cyc/stb/adr/we/dat_i/sel/bl/bry : master -> slave
//   dat_o/ack/lack/err              : slave -> master
// ----------------------------------------------------------------------------
interface ycr1_wbb_sram_ctrl_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned BL = 10
) ();
    localparam int unsigned BW = DW / 8;

    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic [AW-1:0] wbs_adr_i;
    logic          wbs_we_i;
    logic [DW-1:0] wbs_dat_i;
    logic [BW-1:0] wbs_sel_i;
    logic [BL-1:0] wbs_bl_i;
    logic          wbs_bry_i;
    logic [DW-1:0] wbs_dat_o;
    logic          wbs_ack_o;
    logic          wbs_lack_o;
    logic          wbs_err_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
               wbs_bl_i, wbs_bry_i,
        output wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
               wbs_bl_i, wbs_bry_i,
        input  wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
    );
endinterface

// File: rtl/ycr1_wbb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// ycr1_wbb_sram_ctrl
// Burst Wishbone slave terminating bridge bursts onto a single-port SRAM
// macro with 1-cycle read latency. Generates per-beat ack, last-beat lack
// and err for accesses outside the SRAM region.
// Ports:
//   wbs_clk_i, wbs_rst_n : clock, asynchronous active-low reset
//   wbs                  : burst Wishbone slave interface
//   sram_csb_o/web_o     : SRAM chip select / write enable (active low)
//   sram_wmask_o         : SRAM byte write mask
//   sram_addr_o          : SRAM word address
//   sram_din_o/dout_i    : SRAM write / read data
// ----------------------------------------------------------------------------
module ycr1_wbb_sram_ctrl
    import ycr1_wbb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned BL       = 10,
    parameter int unsigned MEM_AW   = 9,
    parameter logic [31:0] BASE_ADR = 32'h0800_0000,
    localparam int unsigned BW      = DW / 8
) (
    input  logic                  wbs_clk_i,
    input  logic                  wbs_rst_n,
    ycr1_wbb_sram_ctrl_if.slave   wbs,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [BW-1:0]         sram_wmask_o,
    output logic [MEM_AW-1:0]     sram_addr_o,
    output logic [DW-1:0]         sram_din_o,
    input  logic [DW-1:0]         sram_dout_i
);

    wbb_state_e        state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [BL-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;

    logic cnt_one;
    logic cnt_nz;
    logic beat;
    logic issue;

    assign cnt_one     = (cnt_q == BL'(1));
    assign cnt_nz      = (cnt_q != '0);
    assign sram_addr_o = addr_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        we_d         = we_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        beat         = 1'b0;
        issue        = 1'b0;
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_wmask_o = '0;
        sram_din_o   = wbs.wbs_dat_i;
        wbs.wbs_dat_o  = sram_dout_i;
        wbs.wbs_ack_o  = 1'b0;
        wbs.wbs_lack_o = 1'b0;
        wbs.wbs_err_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                    addr_d  = wbs.wbs_adr_i[MEM_AW+1:2];
                    cnt_d   = (wbs.wbs_bl_i == '0) ? BL'(1) : wbs.wbs_bl_i;
                    err_d   = !region_hit(32'(wbs.wbs_adr_i), BASE_ADR, MEM_AW + 2);
                    we_d    = wbs.wbs_we_i;
                    state_d = wbs.wbs_we_i ? StWr : StRd;
                end
            end

            StWr: begin
                beat = wbs.wbs_stb_i && wbs.wbs_bry_i;
                if (beat) begin
                    // Out-of-range writes are acked with err but never reach the SRAM.
                    sram_csb_o     = err_q;
                    sram_web_o     = err_q;
                    sram_wmask_o   = wbs.wbs_sel_i;
                    wbs.wbs_ack_o  = 1'b1;
                    wbs.wbs_err_o  = err_q;
                    wbs.wbs_lack_o = cnt_one;
                    addr_d         = addr_q + MEM_AW'(1);
                    cnt_d          = cnt_q - BL'(1);
                    if (cnt_one) begin
                        state_d = StGap;
                    end
                end
            end

            StRd: begin
                if (err_q) begin
                    // Error beats are answered in the same cycle, no SRAM access.
                    beat          = wbs.wbs_stb_i && wbs.wbs_bry_i && cnt_nz;
                    wbs.wbs_dat_o = '0;
                    if (beat) begin
                        wbs.wbs_ack_o  = 1'b1;
                        wbs.wbs_err_o  = 1'b1;
                        wbs.wbs_lack_o = cnt_one;
                        addr_d         = addr_q + MEM_AW'(1);
                        cnt_d          = cnt_q - BL'(1);
                        if (cnt_one) begin
                            state_d = StGap;
                        end
                    end
                end else begin
                    issue = wbs.wbs_stb_i && wbs.wbs_bry_i && cnt_nz;
                    if (issue) begin
                        sram_csb_o = 1'b0;
                        addr_d     = addr_q + MEM_AW'(1);
                        cnt_d      = cnt_q - BL'(1);
                    end
                    pend_d      = issue;
                    pend_last_d = issue && cnt_one;
                    // A read issued last cycle is acked regardless of the current bry.
                    wbs.wbs_ack_o  = pend_q;
                    wbs.wbs_lack_o = pend_q && pend_last_q;
                    if (pend_q && pend_last_q) begin
                        state_d = StGap;
                    end
                end
            end

            StGap: begin
                // Absorbs the bridge's stb drop after lack; stb is not looked at.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n) begin
        if (!wbs_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            we_q        <= we_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

endmodule

// File: tb/tb_ycr1_wbb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ycr1_wbb_sram_ctrl
// Bench for the burst Wishbone SRAM controller: directed bursts followed by
// random bursts, checked against a word-array reference memory and the
// protocol rules (idle cycle, per-beat ack, 1-cycle read latency, gap).
// ----------------------------------------------------------------------------
module tb_ycr1_wbb_sram_ctrl;

    localparam int unsigned Words = 512;
    localparam logic [31:0] Base  = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;

    logic [31:0] sram_mem [Words];
    logic [31:0] ref_mem  [Words];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ycr1_wbb_sram_ctrl_if #(.AW(32), .DW(32), .BL(10)) wbs ();

    ycr1_wbb_sram_ctrl #(
        .AW       (32),
        .DW       (32),
        .BL       (10),
        .MEM_AW   (9),
        .BASE_ADR (Base)
    ) dut (
        .wbs_clk_i    (clk),
        .wbs_rst_n    (rst_n),
        .wbs          (wbs),
        .sram_csb_o   (sram_csb),
        .sram_web_o   (sram_web),
        .sram_wmask_o (sram_wmask),
        .sram_addr_o  (sram_addr),
        .sram_din_o   (sram_din),
        .sram_dout_i  (sram_dout)
    );

    // SRAM macro model: synchronous, 1-cycle read.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic bus_idle();
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_bry_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_bl_i  = '0;
        wbs.wbs_sel_i = '0;
        wbs.wbs_dat_i = '0;
    endtask

    // One burst. bry_mode: 0 = always ready, 1 = random, 2 = pattern pat (LSB first).
    // abort_after != 0 pulls reset right after that many read acks.
    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_burst(input logic we, input logic hit, input int unsigned word,
                             input int unsigned bl, input int bry_mode, input logic [15:0] pat,
                             input int abort_after);
        int unsigned n;
        int unsigned done;
        int unsigned issued;
        int unsigned cycles;
        int unsigned idx;
        logic        prev;
        logic        bry;
        logic        exp_ack;
        logic        exp_issue;
        logic [3:0]  sel;
        logic [31:0] dat;

        n      = (bl == 0) ? 1 : bl;
        done   = 0;
        issued = 0;
        cycles = 0;
        prev   = 1'b0;

        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = (hit ? Base : Base + 32'h1000) + 32'(word * 4);
        wbs.wbs_bl_i  = 10'(bl);
        wbs.wbs_bry_i = 1'b1;
        wbs.wbs_sel_i = 4'hF;
        @(negedge clk);
        check_val("req_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check_val("req_csb", 32'(sram_csb), 32'd1);
        @(posedge clk);
        #1;

        forever begin
            if (bry_mode == 0)      bry = 1'b1;
            else if (bry_mode == 1) bry = ($urandom_range(0, 3) != 0);
            else                    bry = (cycles < 16) ? pat[cycles] : 1'b1;
            sel = (bry_mode == 1) ? 4'($urandom) : 4'hF;
            dat = (bry_mode == 1) ? $urandom : 32'hA5A5_0001 + 32'(done);
            wbs.wbs_bry_i = bry;
            wbs.wbs_sel_i = sel;
            wbs.wbs_dat_i = dat;
            @(negedge clk);

            if (we || !hit) begin
                // Writes and out-of-range reads: one beat per ready cycle.
                check_val("beat_ack", 32'(wbs.wbs_ack_o), 32'(bry));
                check_val("beat_err", 32'(wbs.wbs_err_o), 32'(bry && !hit));
                check_val("beat_lack", 32'(wbs.wbs_lack_o), 32'(bry && done == n - 1));
                if (bry && hit) begin
                    idx = (word + done) % Words;
                    check_val("wr_csb", 32'(sram_csb), 32'd0);
                    check_val("wr_web", 32'(sram_web), 32'd0);
                    check_val("wr_addr", 32'(sram_addr), 32'(idx));
                    check_val("wr_mask", 32'(sram_wmask), 32'(sel));
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
                    end
                end else begin
                    check_val("nobeat_csb", 32'(sram_csb), 32'd1);
                end
                if (bry && !hit && !we) check_val("err_dat", wbs.wbs_dat_o, 32'd0);
                if (bry) done++;
            end else begin
                // In-range read: data comes back one cycle after the SRAM read.
                exp_ack   = prev;
                exp_issue = bry && (issued < n);
                check_val("rd_ack", 32'(wbs.wbs_ack_o), 32'(exp_ack));
                check_val("rd_err", 32'(wbs.wbs_err_o), 32'd0);
                check_val("rd_lack", 32'(wbs.wbs_lack_o), 32'(exp_ack && done == n - 1));
                check_val("rd_csb", 32'(sram_csb), 32'(!exp_issue));
                if (exp_issue) begin
                    check_val("rd_web", 32'(sram_web), 32'd1);
                    check_val("rd_addr", 32'(sram_addr), 32'((word + issued) % Words));
                    issued++;
                end
                if (exp_ack) begin
                    check_val("rd_dat", wbs.wbs_dat_o, ref_mem[(word + done) % Words]);
                    done++;
                end
                prev = exp_issue;
                if (abort_after != 0 && done == abort_after) begin
                    rst_n = 1'b0;
                    #1;
                    check_val("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
                    check_val("rst_lack", 32'(wbs.wbs_lack_o), 32'd0);
                    check_val("rst_csb", 32'(sram_csb), 32'd1);
                    check_val("rst_web", 32'(sram_web), 32'd1);
                    bus_idle();
                    @(posedge clk);
                    #1;
                    check_val("rst_hold_csb", 32'(sram_csb), 32'd1);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                    return;
                end
            end

            if (done == n) break;
            @(posedge clk);
            #1;
            cycles++;
            if (cycles > 200) begin
                check_val("burst_budget", 32'(done), 32'(n));
                break;
            end
        end

        // Gap cycle: no ack, no SRAM access.
        @(posedge clk);
        #1;
        bus_idle();
        @(negedge clk);
        check_val("gap_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check_val("gap_csb", 32'(sram_csb), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < Words; i++) begin
            sram_mem[i] = 32'(i);
            ref_mem[i]  = 32'(i);
        end
        bus_idle();
        rst_n = 1'b0;
        #12;
        check_val("reset_ack", 32'(wbs.wbs_ack_o), 32'd0);
        check_val("reset_lack", 32'(wbs.wbs_lack_o), 32'd0);
        check_val("reset_err", 32'(wbs.wbs_err_o), 32'd0);
        check_val("reset_csb", 32'(sram_csb), 32'd1);
        check_val("reset_web", 32'(sram_web), 32'd1);
        check_val("reset_wmask", 32'(sram_wmask), 32'd0);
        check_val("reset_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_burst(1'b1, 1'b1, 4, 1, 0, 16'h0, 0);        // single write at BASE+0x10
        run_burst(1'b0, 1'b1, 0, 8, 0, 16'h0, 0);        // 8-beat read
        run_burst(1'b1, 1'b1, 0, 4, 2, 16'b101101, 0);   // write with bry 1,0,1,1,0,1
        run_burst(1'b0, 1'b1, 0, 4, 2, 16'b110110, 0);   // read back with stalls
        run_burst(1'b0, 1'b0, 0, 3, 0, 16'h0, 0);        // out-of-range read
        run_burst(1'b1, 1'b0, 8, 2, 0, 16'h0, 0);        // out-of-range write
        run_burst(1'b1, 1'b1, 510, 4, 0, 16'h0, 0);      // write wrap
        run_burst(1'b0, 1'b1, 510, 4, 0, 16'h0, 0);      // read wrap
        run_burst(1'b0, 1'b1, 16, 8, 0, 16'h0, 3);       // reset after 3rd beat
        run_burst(1'b0, 1'b1, 4, 1, 0, 16'h0, 0);        // fresh read after reset
        run_burst(1'b1, 1'b1, 20, 0, 0, 16'h0, 0);       // bl=0 write
        run_burst(1'b0, 1'b1, 20, 0, 0, 16'h0, 0);       // bl=0 read

        repeat (40) begin
            run_burst(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                      $urandom_range(0, Words - 1), $urandom_range(0, 12), 1, 16'h0, 0);
        end

        for (int i = 0; i < Words; i++) begin
            check_val("mem_sweep", sram_mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
